negedge_sync_up_counter_tff: RTL and testbench
==============================================

Name: negedge_sync_up_counter_tff

Overview:
N-bit synchronous modulo-MOD up counter built only from T flip-flops clocked on the falling edge of clk. It is the up-counting counterpart of the team's negedge ripple down counter. All bits share one clock, so q has no ripple skew. Adds count enable, synchronous clear, parallel load, terminal-count and wrap outputs for use as a timebase or prescaler.

Parameters:
N, 6, counter width in bits; legal range 2..16.
MOD, 60, count modulus; q counts 0..MOD-1 then wraps to 0; legal range 2..2**N (elaboration error otherwise).

Ports:
clk  input  1  counter clock; all state updates on negedge clk.
rst  input  1  reset, asynchronous, active-low.
en  input  1  count enable; q increments on a negedge when high.
clr  input  1  synchronous clear to 0.
load  input  1  synchronous parallel load of load_val.
load_val  input  N  value to load.
q  output  N  current count.
tc  output  1  combinational terminal count: (q == MOD-1) & en.
wrap  output  1  registered one-cycle pulse; high for the cycle after q wrapped MOD-1 -> 0.
load_err  output  1  registered one-cycle pulse; high for the cycle after a load with load_val >= MOD.

Behaviour:
- Reset: rst low asynchronously forces q=0, wrap=0, load_err=0 regardless of clk. Release is synchronous to the next negedge; the first count occurs on the first negedge with rst high and en high.
- Priority per negedge: clr > load > en > hold.
- clr=1: q <= 0. wrap=0 and load_err=0 on the next cycle.
- load=1 (clr=0), load_val < MOD: q <= load_val; wrap=0; load_err=0.
- load=1 (clr=0), load_val >= MOD: q <= 0; load_err=1 for one cycle; wrap=0.
- en=1 (clr=0, load=0), q < MOD-1: q <= q+1; wrap=0.
- en=1 (clr=0, load=0), q == MOD-1: q <= 0; wrap=1 for exactly one cycle.
- en=0 with no clr and no load: q holds; wrap=0; load_err=0.
- Implementation is strictly via T inputs, with t[i] computed combinationally:
  - increment: t[i] = &q[i-1:0], with t[0] = 1;
  - wrap or clear: t = q;
  - load: t = q ^ target.
  No direct D-path to q.
- When MOD == 2**N, the wrap path equals the natural binary rollover; tc and wrap still assert at all-ones.
- tc is combinational and may glitch with en. Downstream logic must sample tc on negedge clk only.
- Latency: q reflects any command one negedge after it is presented. wrap and load_err assert on the same negedge that updates q.
- If q somehow holds a value >= MOD (not reachable in normal operation), the next enabled count wraps it to 0 and pulses wrap.

Decomposition:
- Shared package: counter_pkg with localparam helpers: TC_VAL = MOD-1, and a function returning the T-vector for the inputs (q, target).
- Sub-module: tff_en, a negedge T flip-flop with async active-low rst and q/q_bar outputs, instantiated N times in a generate loop.
- Control logic (priority mux, T-vector, wrap/load_err registers) lives in the top module.

Test Plan:
- Reset: rst=0 mid-count at q=37, no clk edge -> q=0, wrap=0, load_err=0 immediately; rst=1 with en=1 -> q=1 after the first negedge.
- Full count: en=1 for 60 negedges from 0 -> q steps 0..59 then 0; tc high only while q=59; wrap high only for the single cycle after 59->0.
- Hold and enable gating: en toggles 1,0,0,1 starting at q=10 -> q = 11, 11, 11, 12; tc=0 throughout.
- Load: load_val=58 -> q=58, then with en=1 -> 59, 0 with a wrap pulse. Next, load_val=63 -> q=0 and load_err pulses once.
- Priority: clr=1, load=1 (load_val=20) and en=1 in the same cycle at q=59 -> q=0, wrap=0, load_err=0. Then load=1 and en=1 -> q=20, not 21.
- Power-of-two modulus: N=4, MOD=16, en=1 -> 15 rolls to 0 with wrap=1; compare against a reference model for 100 random cycles of clr/load/en.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared helpers for the negedge T-flip-flop counter family.
package counter_pkg;

    localparam int unsigned CNT_W_MAX = 16;

    // Terminal count value for a given modulus.
    function automatic int unsigned tc_val(input int unsigned mod);
        return mod - 1;
    endfunction

    // T-vector that moves the flops from q to target in one edge.
    function automatic logic [CNT_W_MAX-1:0] t_vec(input logic [CNT_W_MAX-1:0] q,
                                                   input logic [CNT_W_MAX-1:0] target);
        return q ^ target;
    endfunction

    // T-vector for a binary increment: bit i toggles when all lower bits are one.
    function automatic logic [CNT_W_MAX-1:0] inc_tvec(input logic [CNT_W_MAX-1:0] q);
        logic [CNT_W_MAX-1:0] t;
        t[0] = 1'b1;
        for (int i = 1; i < CNT_W_MAX; i++) begin
            t[i] = t[i-1] & q[i-1];
        end
        return t;
    endfunction

endpackage

// File: rtl/negedge_sync_up_counter_tff_tff_en.sv
// Negative-edge T flip-flop with async active-low reset and complementary outputs.
module tff_en (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic q_bar
);

    // Toggle both outputs on a falling clock edge when t is high.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            q     <= 1'b0;
            q_bar <= 1'b1;
        end else if (t) begin
            q     <= ~q;
            q_bar <= ~q_bar;
        end
    end

endmodule

// File: rtl/negedge_sync_up_counter_tff.sv
// Synchronous modulo-MOD up counter built from negedge T flip-flops.
module negedge_sync_up_counter_tff
    import counter_pkg::*;
#(
    parameter int unsigned N   = 6,
    parameter int unsigned MOD = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         wrap,
    output logic         load_err
);

    localparam logic [N-1:0] TC_VAL = N'(tc_val(MOD));

    if (N < 2 || N > CNT_W_MAX || MOD < 2 || MOD > (32'd1 << N)) begin : g_bad_param
        $error("negedge_sync_up_counter_tff: illegal N/MOD combination");
    end

    logic [N-1:0] q_int;
    logic [N-1:0] q_n;
    logic [N-1:0] t;
    logic [N-1:0] t_inc;
    logic [N-1:0] t_load;
    logic         load_ok;
    logic         at_top;
    logic         wrap_nxt;
    logic         err_nxt;

    assign t_inc   = N'(inc_tvec(CNT_W_MAX'(q_int)));
    assign t_load  = N'(t_vec(CNT_W_MAX'(q_int), CNT_W_MAX'(load_val)));
    assign load_ok = 32'(load_val) < MOD;
    // Values past the terminal count (only reachable by corruption) also wrap.
    assign at_top  = q_int >= TC_VAL;

    // Priority clr > load > en > hold, expressed purely as toggle requests.
    // Clearing toggles every set bit; the inverted flop output gives that set directly.
    always_comb begin
        t        = '0;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (clr) begin
            t = ~q_n;
        end else if (load) begin
            if (load_ok) begin
                t = t_load;
            end else begin
                t       = ~q_n;
                err_nxt = 1'b1;
            end
        end else if (en) begin
            if (at_top) begin
                t        = ~q_n;
                wrap_nxt = 1'b1;
            end else begin
                t = t_inc;
            end
        end
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_bit
        tff_en u_tff (
            .clk   (clk),
            .rst   (rst),
            .t     (t[i]),
            .q     (q_int[i]),
            .q_bar (q_n[i])
        );
    end

    // Status pulses updated on the same edge as the count.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_nxt;
            load_err <= err_nxt;
        end
    end

    assign q  = q_int;
    assign tc = (q_int == TC_VAL) & en;

endmodule

// File: tb/tb_negedge_sync_up_counter_tff.sv
// Self-checking bench: mod-60 and mod-16 counters against an arithmetic model.
module tb_negedge_sync_up_counter_tff;

    logic       clk = 1'b1;
    logic       rst;
    logic       en, clr, load;
    logic [5:0] load_val;
    logic [5:0] q1;
    logic       tc1, wrap1, err1;

    logic       en2, clr2, load2;
    logic [3:0] lv2;
    logic [3:0] q2;
    logic       tc2, wrap2, err2;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    int unsigned m1 = 0, m2 = 0;
    bit          mw1 = 0, me1 = 0, mw2 = 0, me2 = 0;

    always #5 clk = ~clk;

    negedge_sync_up_counter_tff #(.N(6), .MOD(60)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .q(q1), .tc(tc1), .wrap(wrap1), .load_err(err1)
    );

    negedge_sync_up_counter_tff #(.N(4), .MOD(16)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .clr(clr2), .load(load2), .load_val(lv2),
        .q(q2), .tc(tc2), .wrap(wrap2), .load_err(err2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One counter step from the behavioural rules.
    function automatic void step(input int unsigned mod, input bit c, input bit l, input bit e,
                                 input int unsigned lv, inout int unsigned mq,
                                 output bit w, output bit le);
        w  = 0;
        le = 0;
        if (c) mq = 0;
        else if (l) begin
            if (lv < mod) mq = lv;
            else begin
                mq = 0;
                le = 1;
            end
        end else if (e) begin
            if (mq + 1 >= mod) begin
                mq = 0;
                w  = 1;
            end else mq = mq + 1;
        end
    endfunction

    // Reference model advances on the same edges as the design.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            m1 = 0; mw1 = 0; me1 = 0;
            m2 = 0; mw2 = 0; me2 = 0;
        end else begin
            step(60, clr, load, en, 32'(load_val), m1, mw1, me1);
            step(16, clr2, load2, en2, 32'(lv2), m2, mw2, me2);
        end
    end

    // Continuous comparison away from the active edge.
    always @(posedge clk) begin
        chk("q1", 32'(q1), m1);
        chk("tc1", 32'(tc1), 32'((m1 == 59) && en));
        chk("wrap1", 32'(wrap1), 32'(mw1));
        chk("load_err1", 32'(err1), 32'(me1));
        chk("q2", 32'(q2), m2);
        chk("tc2", 32'(tc2), 32'((m2 == 15) && en2));
        chk("wrap2", 32'(wrap2), 32'(mw2));
        chk("load_err2", 32'(err2), 32'(me2));
    end

    task automatic drv1(input bit c, input bit l, input bit e, input logic [5:0] lv);
        clr = c; load = l; en = e; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic drv2(input bit c, input bit l, input bit e, input logic [3:0] lv);
        clr2 = c; load2 = l; en2 = e; lv2 = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        en = 0; clr = 0; load = 0; load_val = '0;
        en2 = 0; clr2 = 0; load2 = 0; lv2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 32'(q1), 0);
        rst = 1'b1;

        // Full count 0..59 -> 0
        for (int i = 0; i < 60; i++) begin
            drv1(0, 0, 1, 6'd0);
            chk("count_q", 32'(q1), 32'((i + 1) % 60));
            if (i == 58) chk("tc_at_59", 32'(tc1), 1);
        end
        chk("wrap_after_59", 32'(wrap1), 1);

        // Hold and enable gating
        drv1(0, 1, 0, 6'd10);
        chk("load10", 32'(q1), 10);
        drv1(0, 0, 1, 6'd0); chk("gate_a", 32'(q1), 11);
        drv1(0, 0, 0, 6'd0); chk("gate_b", 32'(q1), 11);
        drv1(0, 0, 0, 6'd0); chk("gate_c", 32'(q1), 11);
        drv1(0, 0, 1, 6'd0); chk("gate_d", 32'(q1), 12);

        // Load path and illegal load
        drv1(0, 1, 0, 6'd58); chk("load58", 32'(q1), 58);
        drv1(0, 0, 1, 6'd0);  chk("inc59", 32'(q1), 59);
        drv1(0, 0, 1, 6'd0);  chk("wrap_q", 32'(q1), 0);
        chk("wrap_pulse", 32'(wrap1), 1);
        drv1(0, 1, 0, 6'd63); chk("bad_load_q", 32'(q1), 0);
        chk("bad_load_err", 32'(err1), 1);
        drv1(0, 0, 0, 6'd0);  chk("err_one_cycle", 32'(err1), 0);

        // Priority clr > load > en
        drv1(0, 1, 0, 6'd59); chk("load59", 32'(q1), 59);
        drv1(1, 1, 1, 6'd20); chk("prio_clr_q", 32'(q1), 0);
        chk("prio_clr_wrap", 32'(wrap1), 0);
        chk("prio_clr_err", 32'(err1), 0);
        drv1(0, 1, 1, 6'd20); chk("prio_load_q", 32'(q1), 20);

        // Asynchronous reset mid-count
        drv1(0, 1, 0, 6'd37); chk("load37", 32'(q1), 37);
        en = 1; load = 0;
        #1 rst = 1'b0;
        #1;
        chk("async_rst_q", 32'(q1), 0);
        chk("async_rst_wrap", 32'(wrap1), 0);
        chk("async_rst_err", 32'(err1), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        drv1(0, 0, 1, 6'd0); chk("first_count", 32'(q1), 1);
        drv1(0, 0, 0, 6'd0);

        // Power-of-two modulus rollover
        drv2(0, 1, 0, 4'd14); chk("m16_load14", 32'(q2), 14);
        drv2(0, 0, 1, 4'd0);  chk("m16_q15", 32'(q2), 15);
        chk("m16_tc", 32'(tc2), 1);
        drv2(0, 0, 1, 4'd0);  chk("m16_roll", 32'(q2), 0);
        chk("m16_wrap", 32'(wrap2), 1);

        // Random clr/load/en on the power-of-two counter
        for (int i = 0; i < 100; i++) begin
            drv2($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
        end
        drv2(0, 0, 0, 4'd0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
